// File: rtl/random_checker.sv
`default_nettype none
// ============================================================================
//  Module   : random_checker
//  Purpose  : Receive-side BIST monitor for the random engine's serial stream.
//             It fills a shadow register from the first eight valid bits and
//             then predicts each following bit from the feedback taps. It
//             locks after LOCK_LEN consecutive correct predictions. While
//             locked it flywheels on its own predictions, flags and counts
//             every mismatched bit, and drops back to re-sync after LOSS_LEN
//             consecutive mismatches.
//  Ports    : clk       - clock, rising edge
//             rst       - synchronous active-high reset
//             clear     - synchronous restart, same effect as rst
//             tap       - 8-bit feedback tap mask (must match the engine)
//             in_valid  - qualifies in; low holds all state
//             in        - serial bit from the engine
//             locked    - high while locked
//             err       - one-cycle pulse per mismatched bit while locked
//             err_count - saturating count of mismatches while locked
//             bit_count - saturating count of bits checked while locked
//  Revision : 1.0  initial release
// ============================================================================
module random_checker #(
    parameter int CNT_W    = 16,
    parameter int LOCK_LEN = 16,
    parameter int LOSS_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [7:0]       tap,
    input  logic             in_valid,
    input  logic             in,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FILL   = 2'd1;
    localparam logic [1:0] c_SYNC   = 2'd2;
    localparam logic [1:0] c_LOCKED = 2'd3;

    localparam int c_RUN_W  = $clog2(LOCK_LEN + 1);
    localparam int c_MISS_W = $clog2(LOSS_LEN + 1);

    // Last value a counter holds before it reaches its threshold on this bit.
    localparam logic [c_RUN_W-1:0]  c_RUN_LAST  = c_RUN_W'(LOCK_LEN - 1);
    localparam logic [c_MISS_W-1:0] c_MISS_LAST = c_MISS_W'(LOSS_LEN - 1);

    logic [1:0]          r_state;
    logic [7:0]          r_sr;
    logic [3:0]          r_fill;
    logic [c_RUN_W-1:0]  r_run;
    logic [c_MISS_W-1:0] r_miss;
    logic                r_locked;
    logic                r_err;
    logic [CNT_W-1:0]    r_err_count;
    logic [CNT_W-1:0]    r_bit_count;

    logic       w_predict;
    logic       w_match;
    logic [7:0] w_sr_in;
    logic [7:0] w_sr_pred;

    assign w_predict = ^(r_sr & tap);
    assign w_match   = (in == w_predict);
    assign w_sr_in   = {r_sr[6:0], in};
    assign w_sr_pred = {r_sr[6:0], w_predict};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state     <= c_IDLE;
            r_sr        <= 8'd0;
            r_fill      <= 4'd0;
            r_run       <= '0;
            r_miss      <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
            r_bit_count <= '0;
        end else begin
            r_err <= 1'b0;
            if (in_valid) begin
                case (r_state)
                    c_IDLE: begin
                        r_sr    <= w_sr_in;
                        r_fill  <= 4'd1;
                        r_state <= c_FILL;
                    end
                    c_FILL: begin
                        r_sr   <= w_sr_in;
                        r_fill <= r_fill + 4'd1;
                        if (r_fill == 4'd7) begin
                            r_state <= c_SYNC;
                        end
                    end
                    c_SYNC: begin
                        // Shift the received bit so a bad history re-acquires.
                        r_sr <= w_sr_in;
                        if (w_match) begin
                            if (r_run == c_RUN_LAST) begin
                                r_state  <= c_LOCKED;
                                r_locked <= 1'b1;
                                r_run    <= '0;
                                r_miss   <= '0;
                            end else begin
                                r_run <= r_run + 1'b1;
                            end
                        end else begin
                            r_run <= '0;
                        end
                    end
                    c_LOCKED: begin
                        if (!(&r_bit_count)) begin
                            r_bit_count <= r_bit_count + 1'b1;
                        end
                        if (w_match) begin
                            r_miss <= '0;
                            r_sr   <= w_sr_pred;
                        end else begin
                            r_err <= 1'b1;
                            if (!(&r_err_count)) begin
                                r_err_count <= r_err_count + 1'b1;
                            end
                            if (r_miss == c_MISS_LAST) begin
                                r_state  <= c_SYNC;
                                r_locked <= 1'b0;
                                r_run    <= '0;
                                r_miss   <= '0;
                                r_sr     <= w_sr_in;
                            end else begin
                                // Flywheel: a single bad bit costs one error only.
                                r_miss <= r_miss + 1'b1;
                                r_sr   <= w_sr_pred;
                            end
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    assign locked    = r_locked;
    assign err       = r_err;
    assign err_count = r_err_count;
    assign bit_count = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_random_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_random_checker
//  Purpose  : Self-checking bench for random_checker. Two instances (16-bit
//             and 4-bit counters) share one stimulus; each cycle is compared
//             against a queue-based reference model, and scenario tables plus
//             hand sequences check fixed expected results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_random_checker;

    localparam int LOCK_LEN = 16;
    localparam int LOSS_LEN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [7:0]  tap;
    logic        in_valid;
    logic        din;
    logic        locked16, err16, locked4, err4;
    logic [15:0] ec16, bc16;
    logic [3:0]  ec4, bc4;

    always #5 clk = ~clk;

    random_checker #(.CNT_W(16), .LOCK_LEN(LOCK_LEN), .LOSS_LEN(LOSS_LEN)) u_dut16 (
        .clk(clk), .rst(rst), .clear(clear), .tap(tap), .in_valid(in_valid), .in(din),
        .locked(locked16), .err(err16), .err_count(ec16), .bit_count(bc16)
    );

    random_checker #(.CNT_W(4), .LOCK_LEN(LOCK_LEN), .LOSS_LEN(LOSS_LEN)) u_dut4 (
        .clk(clk), .rst(rst), .clear(clear), .tap(tap), .in_valid(in_valid), .in(din),
        .locked(locked4), .err(err4), .err_count(ec4), .bit_count(bc4)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_hist[$];          // received/flywheel history, newest at the back
    int m_filled, m_run, m_miss, m_errs, m_bits;
    bit m_lk, m_err;

    function automatic int sat(input int x, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    function automatic int m_pred();
        int p;
        p = 0;
        for (int k = 0; k < 8; k++) begin
            if (tap[k] && (m_hist.size() > k)) p ^= m_hist[m_hist.size() - 1 - k];
        end
        return p;
    endfunction

    task automatic m_push(input int x);
        m_hist.push_back(x);
        if (m_hist.size() > 8) void'(m_hist.pop_front());
    endtask

    task automatic m_reset();
        m_hist.delete();
        m_filled = 0; m_run = 0; m_miss = 0; m_errs = 0; m_bits = 0;
        m_lk = 0; m_err = 0;
    endtask

    task automatic m_bit(input int b);
        int p;
        if (!m_lk) begin
            if (m_filled < 8) begin
                m_push(b);
                m_filled++;
            end else begin
                p = m_pred();
                m_run = (b == p) ? m_run + 1 : 0;
                m_push(b);
                if (m_run == LOCK_LEN) begin
                    m_lk = 1; m_run = 0; m_miss = 0;
                end
            end
        end else begin
            p = m_pred();
            m_bits++;
            if (b != p) begin
                m_errs++; m_miss++; m_err = 1;
            end else begin
                m_miss = 0;
            end
            if (m_miss == LOSS_LEN) begin
                m_lk = 0; m_run = 0; m_push(b);
            end else begin
                m_push(p);
            end
        end
    endtask

    // One clock: drive inputs, clock, update model, compare both instances.
    task automatic step(input bit v, input bit b, input bit c, input bit r);
        in_valid = v; din = b; clear = c; rst = r;
        @(posedge clk);
        #1;
        m_err = 0;
        if (r || c) m_reset();
        else if (v) m_bit(int'(b));
        chk("locked16", locked16, m_lk);
        chk("err16",    err16,    m_err);
        chk("ec16",     ec16,     sat(m_errs, 16));
        chk("bc16",     bc16,     sat(m_bits, 16));
        chk("locked4",  locked4,  m_lk);
        chk("err4",     err4,     m_err);
        chk("ec4",      ec4,      sat(m_errs, 4));
        chk("bc4",      bc4,      sat(m_bits, 4));
    endtask

    // ---------------- engine stream generator ----------------
    bit [7:0] g_s;
    function automatic bit gen_bit();
        bit o;
        o   = g_s[7];
        g_s = {g_s[6:0], ^(g_s & tap)};
        return o;
    endfunction

    // ---------------- scenario table ----------------
    typedef struct {
        bit [7:0] tp;
        bit [7:0] seed;
        int       nbits;
        int       flo;
        int       fhi;
        bit       gap;
        bit       ev8;
        int       lock_at;
        int       fall_at;
        bit       exp_locked;
        int       exp_ec;
        int       exp_bc;
    } scn_t;

    scn_t tbl[5];

    task automatic run_scn(input int idx, input scn_t s);
        int  n, cyc, lock_at, fall_at;
        bit  b, prev;
        tap = s.tp;
        step(0, 0, 0, 1);
        g_s = s.seed;
        n = 0; cyc = 0; lock_at = 0; fall_at = 0; prev = 0;
        while (n < s.nbits) begin
            if (s.gap && (cyc % 5) >= 2) begin
                step(0, 1'($urandom_range(0, 1)), 0, 0);
            end else begin
                b = gen_bit();
                n++;
                if ((n >= s.flo && n <= s.fhi) || (s.ev8 && n > 24 && (n % 8) == 0)) b = ~b;
                step(1, b, 0, 0);
            end
            if (locked16 && !prev && lock_at == 0) lock_at = n;
            if (!locked16 && prev && fall_at == 0) fall_at = n;
            prev = locked16;
            cyc++;
        end
        chk($sformatf("scn%0d lock_at", idx), lock_at, s.lock_at);
        chk($sformatf("scn%0d fall_at", idx), fall_at, s.fall_at);
        chk($sformatf("scn%0d locked", idx), locked16, s.exp_locked);
        chk($sformatf("scn%0d ec16", idx), ec16, s.exp_ec);
        chk($sformatf("scn%0d bc16", idx), bc16, s.exp_bc);
        chk($sformatf("scn%0d ec4", idx), ec4, sat(s.exp_ec, 4));
        chk($sformatf("scn%0d bc4", idx), bc4, sat(s.exp_bc, 4));
    endtask

    // Restart while locked (by clear or rst), then relock after 24 more bits.
    task automatic restart_seq(input bit use_rst);
        bit b;
        tap = 8'hB8;
        step(0, 0, 0, 1);
        g_s = 8'hA5;
        for (int i = 0; i < 60; i++) step(1, gen_bit(), 0, 0);
        chk("pre-restart locked", locked16, 1);
        chk("pre-restart bc16", bc16, 36);
        b = gen_bit();
        step(1, b, !use_rst, use_rst);
        chk("restart locked", locked16, 0);
        chk("restart ec16", ec16, 0);
        chk("restart bc16", bc16, 0);
        for (int i = 0; i < 23; i++) step(1, gen_bit(), 0, 0);
        chk("relock-23 locked", locked16, 0);
        step(1, gen_bit(), 0, 0);
        chk("relock-24 locked", locked16, 1);
    endtask

    initial begin
        tbl[0] = '{8'hB8, 8'hA5, 200, 0,   -1,  0, 0, 24, 0,   1, 0,  176};
        tbl[1] = '{8'hB8, 8'hA5, 200, 100, 100, 0, 0, 24, 0,   1, 1,  176};
        tbl[2] = '{8'hB8, 8'hA5, 200, 100, 103, 0, 0, 24, 103, 1, 4,  152};
        tbl[3] = '{8'hB8, 8'hA5, 200, 0,   -1,  1, 0, 24, 0,   1, 0,  176};
        tbl[4] = '{8'hB8, 8'hA5, 200, 0,   -1,  0, 1, 24, 0,   1, 22, 176};

        tap = 8'hB8; in_valid = 0; din = 0; clear = 0; rst = 1;
        m_reset();
        step(0, 0, 0, 1);
        chk("reset locked", locked16, 0);
        chk("reset ec16", ec16, 0);
        chk("reset bc16", bc16, 0);

        for (int i = 0; i < 5; i++) run_scn(i + 1, tbl[i]);

        restart_seq(0);
        restart_seq(1);

        // Randomized traffic: random taps, gaps, bit flips and restarts.
        for (int t = 0; t < 6; t++) begin
            bit b;
            tap = 8'($urandom_range(1, 255));
            step(0, 0, 0, 1);
            g_s = 8'($urandom_range(1, 255));
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 149) == 0) begin
                    step(0, 0, 1, 0);
                end else if ($urandom_range(0, 3) == 0) begin
                    step(0, 1'($urandom_range(0, 1)), 0, 0);
                end else begin
                    b = gen_bit();
                    if ($urandom_range(0, 19) == 0) b = ~b;
                    step(1, b, 0, 0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
